alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 132 +++++++++++++
 tb/tb_alu_pipe.sv | 383 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// ARM-style data-processing ALU with a single registered output stage,
// valid/ready handshaking on both sides and an NZCV flag register.
module alu_pipe #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       opcode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             shifter_carry,
    input  logic             s_bit,
    input  logic             flag_wr,
    input  logic [3:0]       flag_wr_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             res_wr,
    output logic [3:0]       res_nzcv,
    output logic [3:0]       flags
);

    typedef enum logic [3:0] {
        OP_AND = 4'b0000, OP_EOR = 4'b0001, OP_SUB = 4'b0010, OP_RSB = 4'b0011,
        OP_ADD = 4'b0100, OP_ADC = 4'b0101, OP_SBC = 4'b0110, OP_RSC = 4'b0111,
        OP_TST = 4'b1000, OP_TEQ = 4'b1001, OP_CMP = 4'b1010, OP_CMN = 4'b1011,
        OP_ORR = 4'b1100, OP_MOV = 4'b1101, OP_BIC = 4'b1110, OP_MVN = 4'b1111
    } opcode_e;

    opcode_e          op;
    logic             accept;
    logic             is_test;
    logic             updates_flags;
    logic             is_arith;
    logic             cin;
    logic [WIDTH-1:0] add_x;
    logic [WIDTH-1:0] add_y;
    logic             add_cin;
    logic [WIDTH:0]   sum;
    logic             add_v;
    logic [WIDTH-1:0] alu_res;
    logic [3:0]       alu_nzcv;
    logic [3:0]       next_nzcv;

    assign op            = opcode_e'(opcode);
    assign in_ready      = !out_valid || out_ready;
    assign accept        = in_valid && in_ready;
    // TST/TEQ/CMP/CMN always set flags and never write a register.
    assign is_test       = (opcode[3:2] == 2'b10);
    assign updates_flags = s_bit || is_test;
    assign cin           = flags[1];

    // Select the adder inputs; subtracts are folded into x + ~y + carry.
    // NOTE: every always_comb output gets a default first so no path
    // through the case statement can infer a latch.
    always_comb begin
        add_x    = a;
        add_y    = b;
        add_cin  = 1'b0;
        is_arith = 1'b1;
        case (op)
            OP_ADD, OP_CMN: begin add_x = a; add_y = b;  add_cin = 1'b0; end
            OP_ADC:         begin add_x = a; add_y = b;  add_cin = cin;  end
            OP_SUB, OP_CMP: begin add_x = a; add_y = ~b; add_cin = 1'b1; end
            OP_SBC:         begin add_x = a; add_y = ~b; add_cin = cin;  end
            OP_RSB:         begin add_x = b; add_y = ~a; add_cin = 1'b1; end
            OP_RSC:         begin add_x = b; add_y = ~a; add_cin = cin;  end
            default:        is_arith = 1'b0;
        endcase
    end

    // Carry-out is bit WIDTH of the widened sum; signed overflow is a
    // same-sign pair of inputs producing a result of the other sign.
    assign sum   = {1'b0, add_x} + {1'b0, add_y} + {{WIDTH{1'b0}}, add_cin};
    assign add_v = (add_x[WIDTH-1] == add_y[WIDTH-1]) &&
                   (sum[WIDTH-1] != add_x[WIDTH-1]);

    // Pick the datapath result: adder output unless the op is logical.
    always_comb begin
        alu_res = sum[WIDTH-1:0];
        case (op)
            OP_AND, OP_TST: alu_res = a & b;
            OP_EOR, OP_TEQ: alu_res = a ^ b;
            OP_ORR:         alu_res = a | b;
            OP_MOV:         alu_res = b;
            OP_BIC:         alu_res = a & ~b;
            OP_MVN:         alu_res = ~b;
            default:        alu_res = sum[WIDTH-1:0];
        endcase
    end

    // Logical ops take C from the shifter and keep V; arithmetic ops use
    // the adder's carry and overflow.
    assign alu_nzcv  = {alu_res[WIDTH-1],
                        (alu_res == '0),
                        is_arith ? sum[WIDTH] : shifter_carry,
                        is_arith ? add_v      : flags[0]};
    assign next_nzcv = updates_flags ? alu_nzcv : flags;

    // Output stage: load on accept, drain when the consumer takes it.
    // NOTE: sequential state is assigned with <= so every register samples
    // pre-edge values, which is what lets back-to-back ops chain flags.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_valid <= 1'b0;
            result    <= '0;
            res_wr    <= 1'b0;
            res_nzcv  <= 4'b0000;
        end else if (accept) begin
            out_valid <= 1'b1;
            result    <= alu_res;
            res_wr    <= !is_test;
            res_nzcv  <= next_nzcv;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

    // Flag register: an accepted flag-setting op beats a direct write.
    always_ff @(posedge clk) begin
        if (reset) begin
            flags <= 4'b0000;
        end else if (accept && updates_flags) begin
            flags <= alu_nzcv;
        end else if (flag_wr) begin
            flags <= flag_wr_data;
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Self-checking bench for alu_pipe: directed cases for the documented
// corner behaviour plus a randomized stream checked against an
// arithmetic reference model, at WIDTH=32 and WIDTH=8.
module tb_alu_pipe;

    typedef struct {
        longint   res;
        logic     wr;
        logic [3:0] nzcv;
        logic     upd;
    } model_t;

    int vectors     = 0;
    int miscompares = 0;

    logic        clk = 1'b0;
    logic        reset = 1'b1;

    logic        in_valid = 1'b0, in_ready, shifter_carry = 1'b0, s_bit = 1'b0;
    logic [3:0]  opcode = 4'h0, flag_wr_data = 4'h0;
    logic        flag_wr = 1'b0, out_valid, out_ready = 1'b0, res_wr;
    logic [31:0] a = '0, b = '0, result;
    logic [3:0]  res_nzcv, flags;

    logic        in_valid8 = 1'b0, in_ready8, shifter_carry8 = 1'b0, s_bit8 = 1'b0;
    logic [3:0]  opcode8 = 4'h0, flag_wr_data8 = 4'h0;
    logic        flag_wr8 = 1'b0, out_valid8, out_ready8 = 1'b1, res_wr8;
    logic [7:0]  a8 = '0, b8 = '0, result8;
    logic [3:0]  res_nzcv8, flags8;

    alu_pipe #(.WIDTH(32)) u_dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .a(a), .b(b), .shifter_carry(shifter_carry),
        .s_bit(s_bit), .flag_wr(flag_wr), .flag_wr_data(flag_wr_data),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .res_wr(res_wr), .res_nzcv(res_nzcv), .flags(flags)
    );

    alu_pipe #(.WIDTH(8)) u_dut8 (
        .clk(clk), .reset(reset), .in_valid(in_valid8), .in_ready(in_ready8),
        .opcode(opcode8), .a(a8), .b(b8), .shifter_carry(shifter_carry8),
        .s_bit(s_bit8), .flag_wr(flag_wr8), .flag_wr_data(flag_wr_data8),
        .out_valid(out_valid8), .out_ready(out_ready8), .result(result8),
        .res_wr(res_wr8), .res_nzcv(res_nzcv8), .flags(flags8)
    );

    always #5 clk = ~clk;

    // Reference model: plain integer arithmetic on unsigned and signed
    // interpretations of the operands, ARM borrow convention for C.
    function automatic model_t alu_model(int w, logic [3:0] op, longint ua, longint ub,
                                         logic sc, logic s, logic [3:0] fl);
        model_t r;
        longint m, half, sa, sb, cin, full, sfull;
        logic   c, v, arith;
        m     = longint'(1) << w;
        half  = m / 2;
        sa    = (ua >= half) ? ua - m : ua;
        sb    = (ub >= half) ? ub - m : ub;
        cin   = longint'(fl[1]);
        arith = 1'b1;
        c     = 1'b0;
        full  = 0;
        sfull = 0;
        case (op)
            4'h4, 4'hB: begin full = ua + ub;       sfull = sa + sb;       c = (full >= m); end
            4'h5:       begin full = ua + ub + cin; sfull = sa + sb + cin; c = (full >= m); end
            4'h2, 4'hA: begin full = ua - ub;             sfull = sa - sb;             c = (full >= 0); end
            4'h6:       begin full = ua - ub - (1 - cin); sfull = sa - sb - (1 - cin); c = (full >= 0); end
            4'h3:       begin full = ub - ua;             sfull = sb - sa;             c = (full >= 0); end
            4'h7:       begin full = ub - ua - (1 - cin); sfull = sb - sa - (1 - cin); c = (full >= 0); end
            4'h0, 4'h8: begin arith = 1'b0; full = ua & ub; end
            4'h1, 4'h9: begin arith = 1'b0; full = ua ^ ub; end
            4'hC:       begin arith = 1'b0; full = ua | ub; end
            4'hD:       begin arith = 1'b0; full = ub; end
            4'hE:       begin arith = 1'b0; full = ua & ~ub; end
            default:    begin arith = 1'b0; full = ~ub; end
        endcase
        r.res  = full & (m - 1);
        v      = (sfull < -half) || (sfull >= half);
        r.upd  = s || (op[3:2] == 2'b10);
        r.wr   = (op[3:2] != 2'b10);
        r.nzcv = {r.res >= half, r.res == 0, arith ? c : sc, arith ? v : fl[0]};
        return r;
    endfunction

    function automatic logic [31:0] pick32();
        case ($urandom_range(0, 5))
            0:       return 32'h0000_0000;
            1:       return 32'hFFFF_FFFF;
            2:       return 32'h8000_0000;
            3:       return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic [3:0] op, logic [31:0] va, logic [31:0] vb, logic sc, logic s);
        in_valid = 1'b1; opcode = op; a = va; b = vb; shifter_carry = sc; s_bit = s;
    endtask

    task automatic do_reset();
        reset = 1'b1; in_valid = 1'b0; flag_wr = 1'b0; in_valid8 = 1'b0; flag_wr8 = 1'b0;
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; out_ready = 1'b0;
        drive(4'h4, 32'h1, 32'h1, 1'b1, 1'b1);
        flag_wr = 1'b1; flag_wr_data = 4'hF;
        in_valid8 = 1'b1; opcode8 = 4'h4; a8 = 8'h1; b8 = 8'h1; s_bit8 = 1'b1;
        flag_wr8 = 1'b1; flag_wr_data8 = 4'hF;
        tick();
        vectors++;
        if ({out_valid, res_wr, result, res_nzcv, flags} !== 42'h0) begin
            miscompares++;
            $display("FAIL reset_state: got ov=%b wr=%b res=%h nzcv=%b flags=%b required all zero",
                     out_valid, res_wr, result, res_nzcv, flags);
        end
        vectors++;
        if ({out_valid8, res_wr8, result8, res_nzcv8, flags8} !== 18'h0) begin
            miscompares++;
            $display("FAIL reset_state8: got ov=%b res=%h flags=%b required all zero",
                     out_valid8, result8, flags8);
        end
        reset = 1'b0; in_valid = 1'b0; flag_wr = 1'b0; in_valid8 = 1'b0; flag_wr8 = 1'b0;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL ready_after_reset: got %b required 1", in_ready);
        end
    endtask

    task automatic test_spec_vectors();
        out_ready = 1'b1;
        drive(4'h4, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b1);
        tick();
        vectors++;
        if ({out_valid, res_wr, result, res_nzcv, flags} !== {1'b1, 1'b1, 32'h0, 4'b0110, 4'b0110}) begin
            miscompares++;
            $display("FAIL adds_carry: got ov=%b wr=%b res=%h nzcv=%b flags=%b required 1 1 00000000 0110 0110",
                     out_valid, res_wr, result, res_nzcv, flags);
        end
        drive(4'h5, 32'h0, 32'h0, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({result, res_nzcv, flags} !== {32'h1, 4'b0110, 4'b0110}) begin
            miscompares++;
            $display("FAIL adc_chain: got res=%h nzcv=%b flags=%b required 00000001 0110 0110",
                     result, res_nzcv, flags);
        end
        drive(4'h2, 32'h8000_0000, 32'h0000_0001, 1'b0, 1'b1);
        tick();
        vectors++;
        if ({result, res_nzcv, flags} !== {32'h7FFF_FFFF, 4'b0011, 4'b0011}) begin
            miscompares++;
            $display("FAIL subs_overflow: got res=%h nzcv=%b flags=%b required 7fffffff 0011 0011",
                     result, res_nzcv, flags);
        end
        drive(4'hA, 32'h5, 32'h5, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({res_wr, result, res_nzcv, flags} !== {1'b0, 32'h0, 4'b0110, 4'b0110}) begin
            miscompares++;
            $display("FAIL cmp_equal: got wr=%b res=%h nzcv=%b flags=%b required 0 00000000 0110 0110",
                     res_wr, result, res_nzcv, flags);
        end
        in_valid = 1'b0;
        drive(4'h4, 32'h1234, 32'h1, 1'b1, 1'b1);
        in_valid = 1'b0;
        tick();
        vectors++;
        if ({out_valid, result, flags} !== {1'b0, 32'h0, 4'b0110}) begin
            miscompares++;
            $display("FAIL idle_no_effect: got ov=%b res=%h flags=%b required 0 00000000 0110",
                     out_valid, result, flags);
        end
    endtask

    task automatic test_backpressure();
        out_ready = 1'b1;
        drive(4'hD, 32'h0, 32'h1234_5678, 1'b1, 1'b1);
        tick();
        out_ready = 1'b0;
        drive(4'h4, 32'h1, 32'h1, 1'b0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            #1;
            vectors++;
            if (in_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL stall_ready[%0d]: got %b required 0", i, in_ready);
            end
            tick();
            vectors++;
            if ({out_valid, res_wr, result, res_nzcv, flags} !== {1'b1, 1'b1, 32'h1234_5678, 4'b0010, 4'b0010}) begin
                miscompares++;
                $display("FAIL stall_hold[%0d]: got ov=%b res=%h nzcv=%b flags=%b required 1 12345678 0010 0010",
                         i, out_valid, result, res_nzcv, flags);
            end
        end
        out_ready = 1'b1;
        #1;
        vectors++;
        if (in_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL release_ready: got %b required 1", in_ready);
        end
        tick();
        vectors++;
        if ({out_valid, result, res_nzcv, flags} !== {1'b1, 32'h2, 4'b0000, 4'b0000}) begin
            miscompares++;
            $display("FAIL release_accept: got ov=%b res=%h nzcv=%b flags=%b required 1 00000002 0000 0000",
                     out_valid, result, res_nzcv, flags);
        end
        in_valid = 1'b0;
    endtask

    task automatic test_flag_wr();
        out_ready = 1'b1; in_valid = 1'b0;
        flag_wr = 1'b1; flag_wr_data = 4'b0001;
        tick();
        vectors++;
        if (flags !== 4'b0001) begin
            miscompares++;
            $display("FAIL flag_wr_idle: got %b required 0001", flags);
        end
        flag_wr_data = 4'b1111;
        drive(4'h0, 32'hF0, 32'h0F, 1'b0, 1'b1);
        tick();
        vectors++;
        if ({result, res_nzcv, flags} !== {32'h0, 4'b0101, 4'b0101}) begin
            miscompares++;
            $display("FAIL flag_wr_alu_wins: got res=%h nzcv=%b flags=%b required 00000000 0101 0101",
                     result, res_nzcv, flags);
        end
        in_valid = 1'b0;
        tick();
        vectors++;
        if (flags !== 4'b1111) begin
            miscompares++;
            $display("FAIL flag_wr_no_accept: got %b required 1111", flags);
        end
        flag_wr_data = 4'b0000;
        drive(4'h5, 32'h1, 32'h1, 1'b0, 1'b0);
        tick();
        vectors++;
        if ({result, res_nzcv, flags} !== {32'h3, 4'b1111, 4'b0000}) begin
            miscompares++;
            $display("FAIL flag_wr_preedge_cin: got res=%h nzcv=%b flags=%b required 00000003 1111 0000",
                     result, res_nzcv, flags);
        end
        in_valid = 1'b0; flag_wr = 1'b0;
    endtask

    task automatic test_reset_mid_stall();
        out_ready = 1'b1;
        drive(4'h4, 32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        tick();
        out_ready = 1'b0;
        drive(4'h1, 32'h3, 32'h5, 1'b0, 1'b1);
        tick();
        vectors++;
        if ({out_valid, flags} !== {1'b1, 4'b0111}) begin
            miscompares++;
            $display("FAIL stall_setup: got ov=%b flags=%b required 1 0111", out_valid, flags);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0; in_valid = 1'b0;
        #1;
        vectors++;
        if ({out_valid, in_ready, result, res_nzcv, flags} !== {1'b0, 1'b1, 32'h0, 4'b0000, 4'b0000}) begin
            miscompares++;
            $display("FAIL reset_mid_stall: got ov=%b rdy=%b res=%h nzcv=%b flags=%b required 0 1 00000000 0000 0000",
                     out_valid, in_ready, result, res_nzcv, flags);
        end
    endtask

    task automatic test_width8();
        model_t      m;
        logic [3:0]  e_flags;
        out_ready8 = 1'b1;
        flag_wr8 = 1'b1; flag_wr_data8 = 4'b0000; in_valid8 = 1'b0;
        tick();
        flag_wr8 = 1'b0;
        in_valid8 = 1'b1; opcode8 = 4'h7; a8 = 8'h01; b8 = 8'h00; s_bit8 = 1'b1; shifter_carry8 = 1'b0;
        tick();
        vectors++;
        if ({result8, res_nzcv8, flags8} !== {8'hFE, 4'b1000, 4'b1000}) begin
            miscompares++;
            $display("FAIL rscs_w8: got res=%h nzcv=%b flags=%b required fe 1000 1000",
                     result8, res_nzcv8, flags8);
        end
        e_flags = 4'b1000;
        for (int i = 0; i < 60; i++) begin
            opcode8 = 4'($urandom_range(0, 15));
            a8 = 8'($urandom_range(0, 255));
            b8 = 8'($urandom_range(0, 255));
            s_bit8 = 1'($urandom_range(0, 1));
            shifter_carry8 = 1'($urandom_range(0, 1));
            m = alu_model(8, opcode8, longint'(a8), longint'(b8), shifter_carry8, s_bit8, e_flags);
            tick();
            vectors++;
            if ({out_valid8, res_wr8, result8, res_nzcv8, flags8} !==
                {1'b1, m.wr, m.res[7:0], m.upd ? m.nzcv : e_flags, m.upd ? m.nzcv : e_flags}) begin
                miscompares++;
                $display("FAIL rand_w8[%0d] op=%h a=%h b=%h: got ov=%b wr=%b res=%h nzcv=%b flags=%b required wr=%b res=%h nzcv=%b",
                         i, opcode8, a8, b8, out_valid8, res_wr8, result8, res_nzcv8, flags8,
                         m.wr, m.res[7:0], m.upd ? m.nzcv : e_flags);
            end
            if (m.upd) e_flags = m.nzcv;
        end
        in_valid8 = 1'b0;
    endtask

    task automatic test_random();
        model_t      m;
        logic        e_ov, e_wr, e_rdy, acc;
        logic [31:0] e_res;
        logic [3:0]  e_nzcv, e_flags;
        do_reset();
        e_ov = 1'b0; e_wr = 1'b0; e_res = '0; e_nzcv = '0; e_flags = '0;
        for (int i = 0; i < 400; i++) begin
            in_valid      = ($urandom_range(0, 3) != 0);
            out_ready     = ($urandom_range(0, 2) != 0);
            opcode        = 4'($urandom_range(0, 15));
            a             = pick32();
            b             = pick32();
            shifter_carry = 1'($urandom_range(0, 1));
            s_bit         = 1'($urandom_range(0, 1));
            flag_wr       = ($urandom_range(0, 7) == 0);
            flag_wr_data  = 4'($urandom_range(0, 15));
            #1;
            e_rdy = !e_ov || out_ready;
            vectors++;
            if (in_ready !== e_rdy) begin
                miscompares++;
                $display("FAIL rand_ready[%0d]: got %b required %b", i, in_ready, e_rdy);
            end
            acc = in_valid && e_rdy;
            m = alu_model(32, opcode, longint'(a), longint'(b), shifter_carry, s_bit, e_flags);
            if (acc) begin
                e_ov   = 1'b1;
                e_res  = m.res[31:0];
                e_wr   = m.wr;
                e_nzcv = m.upd ? m.nzcv : e_flags;
                if (m.upd) e_flags = m.nzcv;
                else if (flag_wr) e_flags = flag_wr_data;
            end else begin
                if (out_ready) e_ov = 1'b0;
                if (flag_wr) e_flags = flag_wr_data;
            end
            tick();
            vectors++;
            if ({out_valid, res_wr, result, res_nzcv, flags} !== {e_ov, e_wr, e_res, e_nzcv, e_flags}) begin
                miscompares++;
                $display("FAIL rand_out[%0d] op=%h a=%h b=%h: got ov=%b wr=%b res=%h nzcv=%b flags=%b required ov=%b wr=%b res=%h nzcv=%b flags=%b",
                         i, opcode, a, b, out_valid, res_wr, result, res_nzcv, flags,
                         e_ov, e_wr, e_res, e_nzcv, e_flags);
            end
        end
        in_valid = 1'b0; flag_wr = 1'b0;
    endtask

    initial begin
        test_reset();
        test_spec_vectors();
        test_backpressure();
        test_flag_wr();
        test_reset_mid_stall();
        test_width8();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
